signal_snapshot: RTL
====================

# signal_snapshot

Edge-triggered capture stage that samples a bus on rising edges of a trigger and buffers the samples in a small FIFO. Snapshots are drained over a valid/ready stream. The most recent capture is also held on a dedicated output that feeds a `read` keep-cell, so debug and observation signals survive non-ungrouped synthesis. It sits between the observed logic and the `read` instance or debug-readout path.

## Interface

Parameters:
- `Width`, default 1: bit width of the sampled signal.
- `T`, default `logic [Width-1:0]`: sample type.
- `Depth`, default 2: number of FIFO entries; must be ≥ 1 and need not be a power of two.
- `CntWidth`, default 8: width of the capture counter.

Ports:
- `clk_i` input, 1 bit: clock. Single clock domain.
- `rst_i` input, 1 bit: reset, synchronous and active-high.
- `clear_i` input, 1 bit: synchronous flush of FIFO, counter and overflow flag.
- `trig_i` input, 1 bit: capture trigger (level input; rising edge detected internally).
- `d_i` input, `T`: signal to sample.
- `valid_o` output, 1 bit: FIFO head is valid.
- `ready_i` input, 1 bit: consumer accepts the head.
- `snap_o` output, `T`: FIFO head data; all zeros when empty.
- `last_o` output, `T`: most recently accepted capture (connects to `read.d_i`).
- `count_o` output, `CntWidth` bits: accepted captures, saturating.
- `overflow_o` output, 1 bit: sticky; a capture was dropped because the FIFO was full.

## Operation

- Edge detect:
  - `trig_q` is a register of `trig_i`, reset value 0.
  - `edge = trig_i & ~trig_q`.
  - A trigger held high produces exactly one capture.
- Push:
  - On `edge`, `d_i` of that same cycle is written at the FIFO tail.
  - The push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the sample is dropped and `overflow_o` is set to 1.
- Pop: `valid_o & ready_i` removes the head.
- Push and pop in the same cycle:
  - Non-empty FIFO: occupancy is unchanged.
  - Empty FIFO: pop is impossible (`valid_o` = 0) and the push proceeds.
- `last_o` loads `d_i` on every accepted push and is unaffected by pops.
- `count_o`:
  - Increments by 1 on every accepted push.
  - Saturates at 2^CntWidth−1 and never wraps.
  - Dropped captures do not count.
- Pointers:
  - Read and write pointers wrap from Depth−1 to 0.
  - Full and empty are derived from an occupancy counter of width $clog2(Depth+1).
- `clear_i`:
  - In the next cycle: FIFO empty, `count_o` = 0, `overflow_o` = 0.
  - `last_o` is retained.
  - `trig_q` still updates normally.
  - An edge or pop in the clear cycle is discarded.
  - `clear_i` has priority over push and pop.
- Stream contract:
  - `valid_o` and `snap_o` are stable while `valid_o & ~ready_i`.
  - `valid_o` does not depend combinationally on `ready_i`.

## Timing

- Reset values of all outputs are 0: `valid_o`, `snap_o`, `last_o`, `count_o`, `overflow_o`. `trig_q` is 0 and the FIFO is empty.
- Reset mid-operation discards all entries within one cycle. `rst_i` dominates `clear_i`.
- Capture latency:
  - Edge in cycle t into an empty FIFO gives `valid_o` = 1 and `snap_o` = sample in cycle t+1.
  - `last_o` and `count_o` update in t+1.
  - `overflow_o` rises in t+1 of the dropped edge.
- Throughput: one push and one pop per cycle.
- `snap_o` is a registered storage read (mux of entries by read pointer) with no combinational path from `d_i`.
- `trig_i` high in the first cycle after reset counts as an edge, since `trig_q` = 0.

## Test plan

- Reset, `trig_i`=0 for 5 cycles -> all outputs 0 and `valid_o`=0 throughout.
- Depth=2: `d_i`=0xA with a 1-cycle trig pulse, `ready_i`=0 -> next cycle `valid_o`=1, `snap_o`=0xA, `last_o`=0xA, `count_o`=1. Then `ready_i`=1 -> `valid_o`=0 and `snap_o`=0 the following cycle.
- Trig held high 10 cycles with `d_i` changing each cycle -> exactly one entry, equal to `d_i` of the first high cycle; `count_o`=1.
- Depth=2, `ready_i`=0, three edges with samples 1, 2, 3 -> FIFO holds 1, 2; `overflow_o`=1; `count_o`=2; `last_o`=2. Fourth edge with `ready_i`=1 in the same cycle (full) -> pop 1, push 4 accepted, `count_o`=3.
- `count_o` saturation: CntWidth=2, 5 accepted captures with continuous drain -> `count_o` sequence 1, 2, 3, 3, 3.
- `clear_i` asserted in the same cycle as an edge, with the FIFO holding 2 entries and `overflow_o`=1 -> next cycle FIFO empty, `count_o`=0, `overflow_o`=0, `last_o` unchanged. Mid-stream `rst_i` -> all outputs 0 next cycle.

Source files
------------

// File: rtl/signal_snapshot.sv
// Edge-triggered bus capture into a small FIFO drained over valid/ready.
// The last accepted capture is also held on last_o for a keep-cell.
module signal_snapshot #(
    parameter int unsigned Width    = 1,
    parameter type         T        = logic [Width-1:0],
    parameter int unsigned Depth    = 2,
    parameter int unsigned CntWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                trig_i,
    input  T                    d_i,
    output logic                valid_o,
    input  logic                ready_i,
    output T                    snap_o,
    output T                    last_o,
    output logic [CntWidth-1:0] count_o,
    output logic                overflow_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned OccW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0]     LastPtr  = PtrW'(Depth - 1);
    localparam logic [OccW-1:0]     DepthOcc = OccW'(Depth);
    localparam logic [CntWidth-1:0] CntMax   = '1;

    logic            trig_q;
    logic            trig_edge;
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] wr_ptr;
    logic [OccW-1:0] occ;
    logic            full;
    logic            push;
    logic            pop;
    logic            drop;
    T                mem [Depth];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        trig_edge = trig_i & ~trig_q;
        full      = (occ == DepthOcc);
        valid_o   = (occ != '0);
        pop       = valid_o & ready_i & ~clear_i;
        // A full FIFO still accepts the push when the head leaves in the same cycle.
        push      = trig_edge & ~clear_i & (~full | pop);
        drop      = trig_edge & ~clear_i & full & ~pop;
        snap_o    = valid_o ? mem[rd_ptr] : '0;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trig_q     <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            occ        <= '0;
            last_o     <= '0;
            count_o    <= '0;
            overflow_o <= 1'b0;
        end else begin
            trig_q <= trig_i;
            if (clear_i) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                occ        <= '0;
                count_o    <= '0;
                overflow_o <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                    last_o <= d_i;
                    if (count_o != CntMax) count_o <= count_o + CntWidth'(1);
                end
                if (pop) rd_ptr <= ptr_inc(rd_ptr);
                case ({push, pop})
                    2'b10:   occ <= occ + OccW'(1);
                    2'b01:   occ <= occ - OccW'(1);
                    default: occ <= occ;
                endcase
                if (drop) overflow_o <= 1'b1;
            end
        end
    end

    // NOTE: storage is not reset; occupancy gates snap_o, so stale entries are never visible.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= d_i;
    end

endmodule
